previn_rx: RTL and testbench

Serial-to-parallel receiver for the PREVIN line on the acquisition path: the counterpart of the PREVIN generator. It frames and samples the single-wire PREVIN stream (one guard bit, then an 8-bit code MSB-first) on the `fdata_G` domain and presents the recovered code with a one-cycle valid strobe. It serves as the loopback checker in the acquisition test path and as the code-capture front end of the chip-side PREVIN consumer. It also checks the guard bit and compares each frame against an expected code.

---
 rtl/previn_pkg.sv | 12 +
 rtl/previn_sipo.sv | 20 ++
 rtl/previn_rx.sv | 106 ++++++++++
 tb/tb_previn_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/previn_pkg.sv
// rtl/previn_pkg.sv - shared PREVIN constants and state encoding
package previn_pkg;

  localparam int PREVIN_BITS  = 8;
  localparam int PREVIN_FRAME = PREVIN_BITS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } previn_state_e;

endpackage

// File: rtl/previn_sipo.sv
// rtl/previn_sipo.sv - serial-in parallel-out shift register, MSB-first assembly
module previn_sipo #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              din,
  output logic [N_BITS-1:0] tap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap <= '0;
    end else if (shift_en) begin
      tap <= {tap[N_BITS-2:0], din};
    end
  end

endmodule

// File: rtl/previn_rx.sv
// rtl/previn_rx.sv - PREVIN serial receiver: guard check, code capture, expected-code compare
module previn_rx
  import previn_pkg::*;
#(
  parameter int N_BITS = PREVIN_BITS,
  parameter int CNT_W  = 8
) (
  input  logic              fdata_G,
  input  logic              rst_n,
  input  logic              previn,
  input  logic              previn_arm,
  input  logic [N_BITS-1:0] previn_expect,
  output logic [N_BITS-1:0] previn_code,
  output logic              previn_valid,
  output logic              guard_err,
  output logic              match,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int BC_W = ($clog2(N_BITS) > 0) ? $clog2(N_BITS) : 1;
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(N_BITS - 1);

  previn_state_e     state, state_next;
  logic [BC_W-1:0]   bit_cnt;
  logic              guard_q;
  logic [N_BITS-1:0] shift;
  logic              start, shift_en, done;
  logic [N_BITS-1:0] code_next;

  previn_sipo #(
    .N_BITS (N_BITS)
  ) u_sipo (
    .clk      (fdata_G),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .din      (previn),
    .tap      (shift)
  );

  // The final data bit bypasses the shifter so the code is registered at the last edge.
  assign code_next = {shift[N_BITS-2:0], previn};

  always_ff @(posedge fdata_G or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    shift_en   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (previn_arm) begin
          start      = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (bit_cnt == '0) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge fdata_G or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      guard_q <= 1'b0;
    end else if (start) begin
      bit_cnt <= BC_LOAD;
      guard_q <= previn;
    end else if (shift_en && (bit_cnt != '0)) begin
      bit_cnt <= bit_cnt - BC_W'(1);
    end
  end

  always_ff @(posedge fdata_G or negedge rst_n) begin
    if (!rst_n) begin
      previn_code  <= '0;
      previn_valid <= 1'b0;
      guard_err    <= 1'b0;
      match        <= 1'b0;
      busy         <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      previn_valid <= done;
      busy         <= (state_next == DATA);
      if (done) begin
        previn_code <= code_next;
        guard_err   <= guard_q;
        match       <= (code_next == previn_expect);
        frame_cnt   <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_previn_rx.sv
// tb/tb_previn_rx.sv - self-checking bench for previn_rx: vector table plus scoreboard
module tb_previn_rx;
  import previn_pkg::*;

  localparam int N  = PREVIN_BITS;
  localparam int CW = 8;

  logic          fdata_G = 1'b0;
  logic          rst_n = 1'b0;
  logic          previn = 1'b0;
  logic          previn_arm = 1'b0;
  logic [N-1:0]  previn_expect = '0;
  logic [N-1:0]  previn_code;
  logic          previn_valid;
  logic          guard_err;
  logic          match;
  logic          busy;
  logic [CW-1:0] frame_cnt;

  previn_rx #(
    .N_BITS (N),
    .CNT_W  (CW)
  ) dut (
    .fdata_G       (fdata_G),
    .rst_n         (rst_n),
    .previn        (previn),
    .previn_arm    (previn_arm),
    .previn_expect (previn_expect),
    .previn_code   (previn_code),
    .previn_valid  (previn_valid),
    .guard_err     (guard_err),
    .match         (match),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 fdata_G = ~fdata_G;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]  code;
    logic          gerr;
    logic          mt;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic         guard;
    logic [N-1:0] code;
    logic [N-1:0] expv;
    logic         gerr;
    logic         mt;
  } vec_t;

  exp_t          sb[$];
  logic [CW-1:0] model_cnt = '0;

  int cyc = 0;
  int valid_seen = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  logic valid_d = 1'b0;

  always @(posedge fdata_G) cyc++;

  // Scoreboard consumer: each valid strobe must match the oldest pushed frame.
  always @(negedge fdata_G) begin
    if (rst_n && previn_valid) begin
      valid_seen++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      check("valid_one_cycle", 32'(valid_d), 32'(0));
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=%0h required=none", previn_code);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("code", 32'(previn_code), 32'(e.code));
        check("guard_err", 32'(guard_err), 32'(e.gerr));
        check("match", 32'(match), 32'(e.mt));
        check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
    valid_d = previn_valid;
  end

  task automatic send_frame(input logic guard, input logic [N-1:0] code,
                            input logic [N-1:0] expv, input logic hold);
    exp_t e;
    model_cnt  = model_cnt + CW'(1);
    e.code     = code;
    e.gerr     = guard;
    e.mt       = (code == expv);
    e.cnt      = model_cnt;
    sb.push_back(e);
    @(negedge fdata_G);
    previn_arm    = 1'b1;
    previn        = guard;
    previn_expect = expv;
    for (int i = N - 1; i >= 0; i--) begin
      @(negedge fdata_G);
      if (i == N - 1) check("busy_in_frame", 32'(busy), 32'(1));
      previn_arm = hold;
      previn     = code[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge fdata_G);
      previn_arm = 1'b0;
      previn     = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(posedge fdata_G);
      #2;
      if (sb.size() == 0) break;
    end
    check("sb_drain", 32'(sb.size()), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_code"}, 32'(previn_code), 32'(0));
    check({tag, "_valid"}, 32'(previn_valid), 32'(0));
    check({tag, "_guard_err"}, 32'(guard_err), 32'(0));
    check({tag, "_match"}, 32'(match), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int   vc0;

  initial begin
    vecs[0] = '{guard: 1'b0, code: 8'hA5, expv: 8'hA5, gerr: 1'b0, mt: 1'b1};
    vecs[1] = '{guard: 1'b1, code: 8'h00, expv: 8'hFF, gerr: 1'b1, mt: 1'b0};
    vecs[2] = '{guard: 1'b0, code: 8'h3C, expv: 8'h3C, gerr: 1'b0, mt: 1'b1};
    vecs[3] = '{guard: 1'b0, code: 8'hC3, expv: 8'hC3, gerr: 1'b0, mt: 1'b1};
    vecs[4] = '{guard: 1'b1, code: 8'h5A, expv: 8'h5A, gerr: 1'b1, mt: 1'b1};
    vecs[5] = '{guard: 1'b0, code: 8'hFF, expv: 8'hFE, gerr: 1'b0, mt: 1'b0};

    repeat (3) @(negedge fdata_G);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Table frames run back-to-back: arm at E0 and E9 of each pair.
    for (int v = 0; v < 6; v++) begin
      exp_t e;
      send_frame(vecs[v].guard, vecs[v].code, vecs[v].expv, 1'b0);
      // Table expectation overrides the derived one so the table is the reference.
      e = sb[sb.size() - 1];
      e.gerr = vecs[v].gerr;
      e.mt   = vecs[v].mt;
      sb[sb.size() - 1] = e;
    end
    idle(1);
    drain();
    check("b2b_spacing", 32'(last_cyc - prev_cyc), 32'(PREVIN_FRAME));
    check("cnt_after_table", 32'(frame_cnt), 32'(6));

    // Arm held high across the whole frame must not restart at E8.
    vc0 = valid_seen;
    send_frame(1'b0, 8'h81, 8'h81, 1'b1);
    @(negedge fdata_G);
    check("busy_after_e8", 32'(busy), 32'(0));
    previn_arm = 1'b0;
    idle(3);
    drain();
    check("arm_hold_single", 32'(valid_seen - vc0), 32'(1));
    check("arm_hold_idle", 32'(busy), 32'(0));

    // Asynchronous reset after E4 of a frame of FF.
    @(negedge fdata_G);
    previn_arm = 1'b1;
    previn     = 1'b0;
    for (int i = N - 1; i >= N - 4; i--) begin
      @(negedge fdata_G);
      previn_arm = 1'b0;
      previn     = 1'b1;
    end
    @(posedge fdata_G);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb.delete();
    model_cnt = '0;
    @(negedge fdata_G);
    previn = 1'b0;
    rst_n  = 1'b1;
    idle(1);
    send_frame(1'b0, 8'h12, 8'h12, 1'b0);
    idle(1);
    drain();
    check("post_rst_code", 32'(previn_code), 32'(8'h12));
    check("post_rst_cnt", 32'(frame_cnt), 32'(1));

    // Counter wrap over 256 completions from a clean reset.
    @(negedge fdata_G);
    rst_n = 1'b0;
    sb.delete();
    model_cnt = '0;
    @(negedge fdata_G);
    rst_n = 1'b1;
    for (int f = 0; f < 255; f++) begin
      logic [N-1:0] c;
      c = N'($urandom);
      send_frame(1'($urandom), c, c ^ N'($urandom_range(0, 1)), 1'b0);
    end
    idle(1);
    drain();
    check("cnt_255", 32'(frame_cnt), 32'(255));
    send_frame(1'b0, 8'h77, 8'h77, 1'b0);
    idle(1);
    drain();
    check("cnt_wrap", 32'(frame_cnt), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
